uart_tx_ctrl: RTL and testbench

Sequencer between the TX FIFO and uart_tx inside the APB UART. It pops one byte at a time from the TX FIFO, presents it to uart_tx, and issues tx_start. It then tracks tx_busy through the frame and inserts a programmable inter-frame gap measured in baud ticks. It also provides flush, a start-handshake timeout, a frame counter and status back to reg_map.

---
 rtl/uart_tx_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// TX sequencer between the TX FIFO and uart_tx: pops a byte, starts the frame,
// follows tx_busy, then holds off for a programmable number of baud ticks.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic                  baud_en,
    input  logic                  empty_tx,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  tx_busy,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  ctrl_busy,
    output logic                  timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        WAIT_BUSY,
        SEND,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [GAP_WIDTH-1:0]  gap_len_q, gap_len_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;
    logic                  frame_done_q, frame_done_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  timeout_hit;
    logic                  flush_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            to_cnt_q      <= '0;
            gap_len_q     <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            to_cnt_q      <= to_cnt_d;
            gap_len_q     <= gap_len_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Flush drains the FIFO straight from IDLE, one entry per clk, without transmitting.
    assign flush_pop = (state_q == IDLE) && flush && !empty_tx;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        to_cnt_d      = to_cnt_q;
        gap_len_d     = gap_len_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        timeout_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush_pop && tx_en && !empty_tx && !tx_busy) begin
                    state_d = POP;
                end
            end
            POP: state_d = LOAD;
            LOAD: begin
                tx_data_d = fifo_dout;
                state_d   = START;
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = SEND;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + CNT_WIDTH'(1);
                    if (gap_cycles != '0) begin
                        // Gap length is latched here so mid-gap writes only affect the next gap.
                        gap_len_d = gap_cycles;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (baud_en) begin
                    gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                    if (gap_cnt_d == gap_len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh timeout wins over a simultaneous clear.
        timeout_err_d = timeout_hit | (timeout_err_q & ~err_clr);
    end

    assign rd_en       = (state_q == POP) || flush_pop;
    assign tx_start    = (state_q == START);
    assign ctrl_busy   = (state_q != IDLE);
    assign tx_data     = tx_data_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a cycle-by-cycle vector table with hand-driven inputs,
// then FIFO/uart_tx/baud models for the multi-cycle scenarios.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, tx_en, flush, err_clr, baud_en, empty_tx, tx_busy;
    logic [7:0] gap_cycles, fifo_dout;
    logic       rd_en, tx_start, frame_done, ctrl_busy, timeout_err;
    logic [7:0] tx_data;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_WIDTH(8), .GAP_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .flush(flush), .err_clr(err_clr),
        .gap_cycles(gap_cycles), .baud_en(baud_en), .empty_tx(empty_tx),
        .fifo_dout(fifo_dout), .tx_busy(tx_busy), .rd_en(rd_en), .tx_data(tx_data),
        .tx_start(tx_start), .frame_done(frame_done), .frame_count(frame_count),
        .ctrl_busy(ctrl_busy), .timeout_err(timeout_err)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    logic manual;
    logic bus_dead;
    logic [7:0] fq[$];
    int bus_ticks;
    int baud_div;

    int nrd, nstart, nfd, first_rd, last_rd, first_start, first_to, gap_baud, min_gap;
    int fd_cyc[$];
    int fall_cyc[$];
    logic [7:0] sent[$];

    typedef struct {
        logic       rst_n, en, fl, em, bz, bd;
        logic [7:0] dout, gap;
        logic [28:0] exp;
    } vec_t;

    vec_t vec[22];

    function automatic vec_t v(input logic r, en, fl, em, bz, bd, input logic [7:0] d, g,
                               input logic e_rd, e_st, e_cb, e_fd, e_to,
                               input logic [7:0] e_d, input logic [15:0] e_c);
        vec_t t;
        t.rst_n = r; t.en = en; t.fl = fl; t.em = em; t.bz = bz; t.bd = bd;
        t.dout = d; t.gap = g;
        t.exp = {e_rd, e_st, e_cb, e_fd, e_to, e_d, e_c};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        nrd = 0; nstart = 0; nfd = 0;
        first_rd = -1; last_rd = -1; first_start = -1; first_to = -1;
        gap_baud = 0; min_gap = 1000;
        fd_cyc.delete(); fall_cyc.delete(); sent.delete();
    endtask

    // One clock: record this cycle's outputs, take the edge, then advance the models.
    task automatic tick();
        logic p_rd, p_start, p_baud;
        #1;
        p_rd = rd_en; p_start = tx_start; p_baud = baud_en;
        if (rd_en) begin
            nrd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (tx_start) begin
            nstart++;
            if (first_start < 0) first_start = cyc;
            sent.push_back(tx_data);
            if (nstart > 1 && gap_baud < min_gap) min_gap = gap_baud;
        end
        if (frame_done) begin nfd++; fd_cyc.push_back(cyc); end
        if (timeout_err && first_to < 0) first_to = cyc;
        if (baud_en) gap_baud++;
        @(posedge clk);
        #1;
        cyc++;
        if (!manual) begin
            if (p_rd && fq.size() > 0) fifo_dout = fq.pop_front();
            empty_tx = (fq.size() == 0);
            if (tx_busy) begin
                if (p_baud) bus_ticks++;
                if (bus_ticks == 10) begin
                    tx_busy = 1'b0;
                    fall_cyc.push_back(cyc);
                    gap_baud = 0;
                end
            end
            if (p_start && !bus_dead) begin tx_busy = 1'b1; bus_ticks = 0; end
            baud_div = (baud_div + 1) % 4;
            baud_en  = (baud_div == 3);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        fq.delete(); tx_busy = 1'b0; fifo_dout = '0; empty_tx = 1'b1;
        bus_ticks = 0; bus_dead = 1'b0; gap_cycles = '0;
        tick();
        rst_n = 1'b1;
        clr_mon();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        manual = 1'b1; bus_dead = 1'b0; baud_div = 0; baud_en = 1'b0;
        rst_n = 1'b0; tx_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        empty_tx = 1'b1; tx_busy = 1'b0; fifo_dout = '0; gap_cycles = '0;
        clr_mon();

        //             rst en fl em bz bd dout   gap  | rd st cb fd to data   cnt
        vec[0]  = v(0, 0, 0, 1, 0, 0, 8'h00, 8'd0,  0, 0, 0, 0, 0, 8'h00, 16'd0);
        vec[1]  = v(1, 1, 0, 0, 0, 0, 8'h00, 8'd0,  1, 0, 1, 0, 0, 8'h00, 16'd0);
        vec[2]  = v(1, 1, 0, 1, 0, 0, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h00, 16'd0);
        vec[3]  = v(1, 1, 0, 1, 0, 0, 8'h3C, 8'd0,  0, 1, 1, 0, 0, 8'h3C, 16'd0);
        vec[4]  = v(1, 1, 0, 1, 0, 0, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd0);
        vec[5]  = v(1, 1, 0, 1, 1, 0, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd0);
        vec[6]  = v(1, 1, 0, 1, 1, 0, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd0);
        vec[7]  = v(1, 1, 0, 1, 0, 0, 8'h3C, 8'd2,  0, 0, 1, 1, 0, 8'h3C, 16'd1);
        vec[8]  = v(1, 1, 0, 1, 0, 0, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd1);
        vec[9]  = v(1, 1, 0, 1, 0, 1, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd1);
        vec[10] = v(1, 1, 0, 1, 0, 0, 8'h3C, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd1);
        vec[11] = v(1, 1, 0, 1, 0, 1, 8'h3C, 8'd0,  0, 0, 0, 0, 0, 8'h3C, 16'd1);
        vec[12] = v(1, 1, 1, 0, 0, 0, 8'h3C, 8'd0,  1, 0, 0, 0, 0, 8'h3C, 16'd1);
        vec[13] = v(1, 0, 1, 1, 0, 0, 8'h3C, 8'd0,  0, 0, 0, 0, 0, 8'h3C, 16'd1);
        vec[14] = v(1, 1, 0, 0, 1, 0, 8'h3C, 8'd0,  0, 0, 0, 0, 0, 8'h3C, 16'd1);
        vec[15] = v(1, 1, 0, 0, 0, 0, 8'h3C, 8'd0,  1, 0, 1, 0, 0, 8'h3C, 16'd1);
        vec[16] = v(1, 1, 0, 1, 0, 0, 8'h81, 8'd0,  0, 0, 1, 0, 0, 8'h3C, 16'd1);
        vec[17] = v(1, 1, 0, 1, 0, 0, 8'h81, 8'd0,  0, 1, 1, 0, 0, 8'h81, 16'd1);
        vec[18] = v(1, 1, 0, 1, 0, 0, 8'h81, 8'd0,  0, 0, 1, 0, 0, 8'h81, 16'd1);
        vec[19] = v(1, 1, 0, 1, 1, 0, 8'h81, 8'd0,  0, 0, 1, 0, 0, 8'h81, 16'd1);
        vec[20] = v(1, 1, 0, 1, 0, 0, 8'h81, 8'd0,  0, 0, 0, 1, 0, 8'h81, 16'd2);
        vec[21] = v(1, 1, 0, 1, 0, 0, 8'h81, 8'd0,  0, 0, 0, 0, 0, 8'h81, 16'd2);

        for (int i = 0; i < 22; i++) begin
            rst_n = vec[i].rst_n; tx_en = vec[i].en; flush = vec[i].fl;
            empty_tx = vec[i].em; tx_busy = vec[i].bz; baud_en = vec[i].bd;
            fifo_dout = vec[i].dout; gap_cycles = vec[i].gap;
            tick();
            check($sformatf("vec[%0d] {rd,st,cb,fd,to,data,cnt}", i),
                  32'({rd_en, tx_start, ctrl_busy, frame_done, timeout_err, tx_data, frame_count}),
                  32'(vec[i].exp));
        end

        manual = 1'b0;
        baud_en = 1'b0;

        // Single byte, no gap.
        do_reset();
        fq.push_back(8'hA5); empty_tx = 1'b0;
        n0 = cyc; tx_en = 1'b1;
        repeat (80) tick();
        check("t1_rd_cycle", 32'(first_rd - n0), 32'd1);
        check("t1_start_cycle", 32'(first_start - n0), 32'd3);
        check("t1_tx_data", sent.size() > 0 ? 32'(sent[0]) : 32'hDEAD, 32'hA5);
        check("t1_frame_done_cnt", 32'(nfd), 32'd1);
        check("t1_done_after_fall",
              (fd_cyc.size() > 0 && fall_cyc.size() > 0) ? 32'(fd_cyc[0] - fall_cyc[0]) : 32'hDEAD,
              32'd1);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        check("t1_ctrl_busy", 32'(ctrl_busy), 32'd0);

        // Three bytes with a two-tick gap.
        do_reset();
        gap_cycles = 8'd2;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); empty_tx = 1'b0;
        tx_en = 1'b1;
        repeat (250) tick();
        check("t2_starts", 32'(nstart), 32'd3);
        check("t2_byte0", sent.size() > 0 ? 32'(sent[0]) : 32'hDEAD, 32'h11);
        check("t2_byte1", sent.size() > 1 ? 32'(sent[1]) : 32'hDEAD, 32'h22);
        check("t2_byte2", sent.size() > 2 ? 32'(sent[2]) : 32'hDEAD, 32'h33);
        check("t2_min_gap_ge2", 32'(min_gap >= 2), 32'd1);
        check("t2_frame_count", 32'(frame_count), 32'd3);

        // Start-handshake timeout: WAIT_BUSY entered at n0+4, error visible 16 clks later.
        do_reset();
        bus_dead = 1'b1;
        fq.push_back(8'h5A); empty_tx = 1'b0;
        n0 = cyc; tx_en = 1'b1;
        repeat (30) tick();
        check("t3_timeout_cycle", 32'(first_to - n0), 32'd20);
        check("t3_timeout_err", 32'(timeout_err), 32'd1);
        check("t3_idle", 32'(ctrl_busy), 32'd0);
        check("t3_fifo_empty", 32'(fq.size()), 32'd0);
        check("t3_frame_count", 32'(frame_count), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_clr", 32'(timeout_err), 32'd0);
        // Second timeout while err_clr is held: set wins for one cycle, then clears.
        clr_mon();
        fq.push_back(8'h77); empty_tx = 1'b0; err_clr = 1'b1;
        n0 = cyc;
        repeat (30) tick();
        check("t3_retx_pop", 32'(nrd), 32'd1);
        check("t3_set_over_clr", 32'(first_to - n0), 32'd20);
        check("t3_cleared_after", 32'(timeout_err), 32'd0);
        err_clr = 1'b0;

        // Flush four entries with transmit disabled.
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'hC0 + i));
        empty_tx = 1'b0; tx_en = 1'b0; flush = 1'b1;
        repeat (8) tick();
        check("t4_rd_count", 32'(nrd), 32'd4);
        check("t4_rd_consecutive", 32'(last_rd - first_rd), 32'd3);
        check("t4_fifo_empty", 32'(fq.size()), 32'd0);
        check("t4_rd_low", 32'(rd_en), 32'd0);
        check("t4_no_start_done", 32'(nstart + nfd), 32'd0);
        flush = 1'b0;

        // Disable mid-frame.
        do_reset();
        for (int i = 0; i < 3; i++) fq.push_back(8'(8'h41 + i));
        empty_tx = 1'b0; tx_en = 1'b1;
        for (int i = 0; i < 20 && !tx_busy; i++) tick();
        check("t5_busy_seen", 32'(tx_busy), 32'd1);
        tick(); tick();
        tx_en = 1'b0;
        repeat (100) tick();
        check("t5_frame_done", 32'(nfd), 32'd1);
        check("t5_frame_count", 32'(frame_count), 32'd1);
        check("t5_fifo_left", 32'(fq.size()), 32'd2);
        check("t5_rd_count", 32'(nrd), 32'd1);

        // Reset during SEND of the sixth frame.
        do_reset();
        for (int i = 0; i < 7; i++) fq.push_back(8'(8'h60 + i));
        empty_tx = 1'b0; tx_en = 1'b1;
        for (int i = 0; i < 600 && !(frame_count == 16'd5 && tx_busy); i++) tick();
        check("t6_reached_5", 32'(frame_count), 32'd5);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        tx_busy = 1'b0; bus_ticks = 0;
        rst_n = 1'b1;
        #1;
        check("t6_outputs_zero",
              32'({rd_en, tx_start, ctrl_busy, frame_done, timeout_err, tx_data}), 32'd0);
        check("t6_frame_count", 32'(frame_count), 32'd0);
        tick();
        check("t6_pop_after_reset", 32'(rd_en), 32'd1);
        check("t6_ctrl_busy", 32'(ctrl_busy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
